// File: rtl/accum_sram_arbiter.sv
// Two-requester 1R1W SRAM arbiter: independent round-robin read/write ports with a tagged read-return pipeline.
// Optional requester lock (hold both ports for one requester) is built when SRAM_ARB_LOCK_EN is defined.
module accum_sram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req0,
    input  logic              rd_req1,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic              rd_gnt0,
    output logic              rd_gnt1,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              wr_req0,
    input  logic              wr_req1,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    output logic              wr_gnt0,
    output logic              wr_gnt1,
    input  logic              lock0,
    input  logic              lock1,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [DATA_W-1:0] sram_write_data
);

    logic rd_ptr, wr_ptr;
    logic mask0, mask1;
    logic rd_r0, rd_r1, wr_r0, wr_r1;
    logic rd_acc, wr_acc;
    logic vld_p0, vld_p1;
    logic id_p0, id_p1;

`ifdef SRAM_ARB_LOCK_EN
    logic own_vld, own_id, own_lock, own_act;

    // Ownership lapses combinationally in the cycle the owner's lock drops.
    assign own_lock = own_id ? lock1 : lock0;
    assign own_act  = own_vld && own_lock;
    assign mask0    = own_act && own_id;
    assign mask1    = own_act && !own_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_vld <= 1'b0;
            own_id  <= 1'b0;
        end else if (own_vld) begin
            if (!own_lock)
                own_vld <= 1'b0;
        end else if ((rd_gnt0 || wr_gnt0) && lock0) begin
            own_vld <= 1'b1;
            own_id  <= 1'b0;
        end else if ((rd_gnt1 || wr_gnt1) && lock1) begin
            own_vld <= 1'b1;
            own_id  <= 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
    assign mask0       = 1'b0;
    assign mask1       = 1'b0;
`endif

    assign rd_r0 = rd_req0 && !mask0;
    assign rd_r1 = rd_req1 && !mask1;
    assign wr_r0 = wr_req0 && !mask0;
    assign wr_r1 = wr_req1 && !mask1;

    assign rd_gnt0 = rd_r0 && (!rd_r1 || !rd_ptr);
    assign rd_gnt1 = rd_r1 && (!rd_r0 || rd_ptr);
    assign wr_gnt0 = wr_r0 && (!wr_r1 || !wr_ptr);
    assign wr_gnt1 = wr_r1 && (!wr_r0 || wr_ptr);

    assign rd_acc = rd_gnt0 || rd_gnt1;
    assign wr_acc = wr_gnt0 || wr_gnt1;

    // Stage p0: accepted request registered onto SRAM ports, tag enters pipe.
    // Stage p1: tag aligned with sram_read_data returned by the SRAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr             <= 1'b0;
            wr_ptr             <= 1'b0;
            vld_p0             <= 1'b0;
            vld_p1             <= 1'b0;
            id_p0              <= 1'b0;
            id_p1              <= 1'b0;
            sram_read_address  <= '0;
            sram_write_enable  <= 1'b0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
        end else begin
            if (rd_gnt0)
                rd_ptr <= 1'b1;
            else if (rd_gnt1)
                rd_ptr <= 1'b0;
            if (wr_gnt0)
                wr_ptr <= 1'b1;
            else if (wr_gnt1)
                wr_ptr <= 1'b0;

            if (rd_acc)
                sram_read_address <= rd_gnt1 ? rd_addr1 : rd_addr0;
            vld_p0 <= rd_acc;
            id_p0  <= rd_gnt1;
            vld_p1 <= vld_p0;
            id_p1  <= id_p0;

            sram_write_enable <= wr_acc;
            if (wr_acc) begin
                sram_write_address <= wr_gnt1 ? wr_addr1 : wr_addr0;
                sram_write_data    <= wr_gnt1 ? wr_data1 : wr_data0;
            end
        end
    end

    assign rd_valid0 = vld_p1 && !id_p1;
    assign rd_valid1 = vld_p1 && id_p1;
    assign rd_data0  = sram_read_data;
    assign rd_data1  = sram_read_data;

endmodule

// File: tb/tb_accum_sram_arbiter.sv
// Self-checking bench for accum_sram_arbiter with a behavioural 1R1W SRAM and a read-response scoreboard.
module tb_accum_sram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req0, rd_req1;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1;
    logic              rd_gnt0, rd_gnt1;
    logic              rd_valid0, rd_valid1;
    logic [DATA_W-1:0] rd_data0, rd_data1;
    logic              wr_req0, wr_req1;
    logic [ADDR_W-1:0] wr_addr0, wr_addr1;
    logic [DATA_W-1:0] wr_data0, wr_data1;
    logic              wr_gnt0, wr_gnt1;
    logic              lock0, lock1;
    logic [ADDR_W-1:0] sram_read_address;
    logic [DATA_W-1:0] sram_read_data;
    logic              sram_write_enable;
    logic [ADDR_W-1:0] sram_write_address;
    logic [DATA_W-1:0] sram_write_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } rsp_t;
    rsp_t sb_q[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    accum_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .rd_req0(rd_req0), .rd_req1(rd_req1), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_gnt0(rd_gnt0), .rd_gnt1(rd_gnt1), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr_req0(wr_req0), .wr_req1(wr_req1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
        .lock0(lock0), .lock1(lock1),
        .sram_read_address(sram_read_address), .sram_read_data(sram_read_data),
        .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
        .sram_write_data(sram_write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {16'hA5A5, a};
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++)
            mem[i] = init_word(ADDR_W'(i));
    end

    // Behavioural SRAM: registered read, read-before-write on the same address.
    always @(posedge clk) begin
        if (sram_write_enable)
            mem[sram_write_address] <= sram_write_data;
        sram_read_data <= mem[sram_read_address];
        cyc <= cyc + 1;
    end

    // Scoreboard consumer: every rd_valid must match the oldest expected response.
    always @(negedge clk) begin
        if (!reset && (rd_valid0 || rd_valid1)) begin
            n_checks++;
            if (rd_valid0 && rd_valid1) begin
                n_fail++;
                $display("FAIL rsp_both_valid: rd_valid0=%0b rd_valid1=%0b required one-hot", rd_valid0, rd_valid1);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: rd_valid0=%0b rd_valid1=%0b data=%h required no response",
                         rd_valid0, rd_valid1, sram_read_data);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                if (rd_valid1 !== e.id || (e.id ? rd_data1 : rd_data0) !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rsp_match: got id=%0b data=%h cyc=%0d, required id=%0b data=%h cyc=%0d",
                             rd_valid1, e.id ? rd_data1 : rd_data0, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    task automatic clear_inputs();
        rd_req0 = 0; rd_req1 = 0; rd_addr0 = '0; rd_addr1 = '0;
        wr_req0 = 0; wr_req1 = 0; wr_addr0 = '0; wr_addr1 = '0;
        wr_data0 = '0; wr_data1 = '0; lock0 = 0; lock1 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic drain(input string name);
        clear_inputs();
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (sram_write_enable !== 1'b0 || sram_write_address !== '0 || sram_write_data !== '0 ||
            sram_read_address !== '0 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: we=%b wa=%h wd=%h ra=%h v0=%b v1=%b required all zero",
                     sram_write_enable, sram_write_address, sram_write_data, sram_read_address, rd_valid0, rd_valid1);
        end
        #1;
        n_checks++;
        if ({rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle_grants: got %b required 0000", {rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1});
        end
    endtask

    task automatic test_rr_read();
        logic              exp;
        logic [ADDR_W-1:0] a;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rd_req0 = 1; rd_addr0 = 16'h0010;
            rd_req1 = 1; rd_addr1 = 16'h0020;
            exp = (k % 2) == 1;
            a   = exp ? 16'h0020 : 16'h0010;
            #1;
            n_checks++;
            if (rd_gnt0 !== !exp || rd_gnt1 !== exp) begin
                n_fail++;
                $display("FAIL rr_read_gnt[%0d]: got gnt0=%b gnt1=%b required gnt0=%b gnt1=%b",
                         k, rd_gnt0, rd_gnt1, !exp, exp);
            end
            sb_q.push_back('{id: exp, data: init_word(a), cyc: cyc + 2});
            @(negedge clk);
            n_checks++;
            if (sram_read_address !== a) begin
                n_fail++;
                $display("FAIL rr_read_addr[%0d]: got %h required %h", k, sram_read_address, a);
            end
        end
        drain("rr_read");
        n_checks++;
        if (sram_read_address !== 16'h0020) begin
            n_fail++;
            $display("FAIL rd_addr_hold: got %h required 0020", sram_read_address);
        end
    endtask

    task automatic test_write_single();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr_req1 = 1; wr_addr1 = 16'h0005; wr_data1 = 32'h3F800000;
            #1;
            n_checks++;
            if (wr_gnt1 !== 1'b1 || wr_gnt0 !== 1'b0 || rd_gnt0 !== 1'b0 || rd_gnt1 !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_single_gnt[%0d]: got wg0=%b wg1=%b rg0=%b rg1=%b required 0 1 0 0",
                         k, wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1);
            end
            @(negedge clk);
            n_checks++;
            if (sram_write_enable !== 1'b1 || sram_write_address !== 16'h0005 || sram_write_data !== 32'h3F800000) begin
                n_fail++;
                $display("FAIL wr_single_strobe[%0d]: got we=%b wa=%h wd=%h required 1 0005 3f800000",
                         k, sram_write_enable, sram_write_address, sram_write_data);
            end
        end
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (sram_write_enable !== 1'b0 || sram_write_address !== 16'h0005 || sram_write_data !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL wr_idle_hold: got we=%b wa=%h wd=%h required 0 0005 3f800000",
                     sram_write_enable, sram_write_address, sram_write_data);
        end
    endtask

    task automatic test_back_to_back_write();
        logic              exp;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr_req0 = 1; wr_addr0 = 16'h0200; wr_data0 = 32'hAAAA0000 + k;
            wr_req1 = 1; wr_addr1 = 16'h0300; wr_data1 = 32'hBBBB0000 + k;
            exp = (k % 2) == 1;
            a = exp ? 16'h0300 : 16'h0200;
            d = exp ? 32'hBBBB0000 + k : 32'hAAAA0000 + k;
            #1;
            n_checks++;
            if (wr_gnt0 !== !exp || wr_gnt1 !== exp) begin
                n_fail++;
                $display("FAIL b2b_wr_gnt[%0d]: got %b%b required %b%b", k, wr_gnt0, wr_gnt1, !exp, exp);
            end
            @(negedge clk);
            n_checks++;
            if (sram_write_enable !== 1'b1 || sram_write_address !== a || sram_write_data !== d) begin
                n_fail++;
                $display("FAIL b2b_wr_port[%0d]: got we=%b wa=%h wd=%h required 1 %h %h",
                         k, sram_write_enable, sram_write_address, sram_write_data, a, d);
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_concurrent();
        do_reset();
        rd_req0 = 1; rd_addr0 = 16'h0001;
        wr_req1 = 1; wr_addr1 = 16'h0100; wr_data1 = 32'h12345678;
        #1;
        n_checks++;
        if ({rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1} !== 4'b1001) begin
            n_fail++;
            $display("FAIL concurrent_gnt: got %b required 1001", {rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1});
        end
        sb_q.push_back('{id: 1'b0, data: init_word(16'h0001), cyc: cyc + 2});
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (sram_read_address !== 16'h0001 || sram_write_enable !== 1'b1 ||
            sram_write_address !== 16'h0100 || sram_write_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL concurrent_ports: got ra=%h we=%b wa=%h wd=%h required 0001 1 0100 12345678",
                     sram_read_address, sram_write_enable, sram_write_address, sram_write_data);
        end
        drain("concurrent");
    endtask

    task automatic test_lock();
        logic              exp;
        logic [ADDR_W-1:0] a;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            lock0 = (k < 8);
            rd_req0 = 1; rd_addr0 = 16'h0040 + 16'(k);
            rd_req1 = 1; rd_addr1 = 16'h0080;
`ifdef SRAM_ARB_LOCK_EN
            exp = (k == 8);
`else
            exp = (k % 2) == 1;
`endif
            a = exp ? 16'h0080 : 16'h0040 + 16'(k);
            #1;
            n_checks++;
            if (rd_gnt0 !== !exp || rd_gnt1 !== exp) begin
                n_fail++;
                $display("FAIL lock_gnt[%0d]: got gnt0=%b gnt1=%b required gnt0=%b gnt1=%b",
                         k, rd_gnt0, rd_gnt1, !exp, exp);
            end
            sb_q.push_back('{id: exp, data: init_word(a), cyc: cyc + 2});
            @(negedge clk);
        end
        drain("lock");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rd_req0 = 1; rd_addr0 = 16'h0010;
        rd_req1 = 1; rd_addr1 = 16'h0020;
        @(negedge clk);
        wr_req1 = 1; wr_addr1 = 16'h0033; wr_data1 = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_inputs();
        #1;
        n_checks++;
        if (sram_write_enable !== 1'b0 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_async: got we=%b v0=%b v1=%b required 0 0 0",
                     sram_write_enable, rd_valid0, rd_valid1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || sram_write_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL midflight_release[%0d]: got v0=%b v1=%b we=%b required 0 0 0",
                         k, rd_valid0, rd_valid1, sram_write_enable);
            end
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        wr_req0 = 1; wr_addr0 = 16'h0008; wr_data0 = 32'h40490FDB;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rd_req1 = 1; rd_addr1 = 16'h0008;
        #1;
        n_checks++;
        if (rd_gnt1 !== 1'b1 || rd_gnt0 !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_gnt: got gnt0=%b gnt1=%b required 0 1", rd_gnt0, rd_gnt1);
        end
        sb_q.push_back('{id: 1'b1, data: 32'h40490FDB, cyc: cyc + 2});
        @(negedge clk);
        drain("raw");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rr_read();
        test_write_single();
        test_back_to_back_write();
        test_concurrent();
        test_lock();
        test_reset_midflight();
        test_write_then_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
